// File: rtl/csr_counter_pkg.sv
// Shared constants for the counter/timer CSR bank: address map, csr_op encodings, inhibit bit layout.
// No timing of its own; helpers are pure functions.
// No backpressure involved.
package csr_counter_pkg;

    localparam logic [1:0] CSR_OP_RD = 2'b00;
    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;
    localparam logic [1:0] CSR_OP_RC = 2'b11;

    localparam logic [3:0]  CSR_USER_PAGE     = 4'hC;
    localparam logic [3:0]  CSR_MACH_PAGE     = 4'hB;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MCOUNTOVF     = 12'h7C0;

    localparam int INH_CY   = 0;
    localparam int INH_TM   = 1;
    localparam int INH_IR   = 2;
    localparam int INH_HPM0 = 3;

    // Bits that correspond to a real, inhibitable counter; time (bit 1) is never included.
    function automatic logic [31:0] inh_mask(input int nhpm);
        logic [31:0] m;
        m         = '0;
        m[INH_CY] = 1'b1;
        m[INH_IR] = 1'b1;
        for (int i = 0; i < nhpm; i++) m[INH_HPM0 + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] old,
                                              input logic [31:0] wd);
        case (op)
            CSR_OP_RW: return wd;
            CSR_OP_RS: return old | wd;
            default:   return old & ~wd;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter_bank_if.sv
// CSR access bus between core decode (master) and the counter bank (slave).
// Read data, hit and illegal are combinational from the address/strobe.
// No backpressure: every access completes in the cycle it is presented.
interface csr_counter_bank_if;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        csr_illegal;

    modport master (output csr_addr, csr_we, csr_op, csr_wdata,
                    input  csr_rdata, csr_hit, csr_illegal);
    modport slave  (input  csr_addr, csr_we, csr_op, csr_wdata,
                    output csr_rdata, csr_hit, csr_illegal);
endinterface

// File: rtl/csr_counter_cell.sv
// One W-bit counter with independent lo/hi 32-bit write ports and a wrap flag.
// Writes and increments land on the next clk edge; wrap is combinational.
// No backpressure; a write in the same cycle as an increment wins.
module csr_counter_cell #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         we_lo,
    input  logic         we_hi,
    input  logic [31:0]  wdat,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (we_lo) begin
            cnt[31:0] <= wdat;
        end else if (we_hi) begin
            cnt[W-1:32] <= wdat[W-33:0];
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign wrap = inc && !we_lo && !we_hi && (&cnt);

endmodule

// File: rtl/csr_counter_bank.sv
// RV32 counter/timer CSRs (cycle, time, instret, hpm) with mcountinhibit; CSR_OVF_IRQ_EN adds overflow CSR 0x7C0.
// Reads combinational; writes, increments and the time prescaler update on the next clk edge.
// No backpressure: every CSR access completes in its cycle.
module csr_counter_bank
    import csr_counter_pkg::*;
#(
    parameter  int COUNTER_W = 64,
    parameter  int NUM_HPM   = 4,
    parameter  int TICK_DIV  = 50000000,
    localparam int EVT_W     = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic               clk,
    input  logic               rst,
    csr_counter_bank_if.slave  csr,
    input  logic               retire,
    input  logic [EVT_W-1:0]   hpm_evt,
    output logic               ovf_irq
);

    localparam int              NUM_CH   = NUM_HPM + 2;
    localparam logic [31:0]     CNT_MASK = inh_mask(NUM_HPM);
    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [COUNTER_W-1:0] cnt_q [NUM_CH];
    logic [NUM_CH-1:0]    ch_inc, ch_we_lo, ch_we_hi, ch_wrap;
    logic [COUNTER_W-1:0] time_q;
    logic [PRE_W-1:0]     pre_q;
    logic [31:0]          inh_q, wrap_bits, rd_dat, wr_dat;
    logic [63:0]          cnt_val;
    logic [4:0]           idx;
    logic [3:0]           page;
    logic                 hi, page_ok, ctr_sel, tm_sel, hit, illegal, wr_ok;
    int                   sel_ch;
`ifdef CSR_OVF_IRQ_EN
    logic [31:0]          ovf_q, ovf_d;
`endif

    // Counter channels: 0 = cycle, 1 = instret, 2+k = hpm k; address index = channel + (channel != 0).
    always_comb begin
        idx     = csr.csr_addr[4:0];
        hi      = csr.csr_addr[7];
        page    = csr.csr_addr[11:8];
        sel_ch  = (idx == 5'd0) ? 0 : int'(idx) - 1;
        page_ok = (csr.csr_addr[6:5] == 2'b00) &&
                  (page == CSR_USER_PAGE || page == CSR_MACH_PAGE);
        ctr_sel = page_ok && CNT_MASK[idx];
        tm_sel  = page_ok && (idx == 5'(INH_TM)) && (page == CSR_USER_PAGE);
        cnt_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_ch == c) cnt_val = 64'(cnt_q[c]);
        end
        if (tm_sel) cnt_val = 64'(time_q);
        hit    = 1'b0;
        rd_dat = '0;
        if (ctr_sel || tm_sel) begin
            hit    = 1'b1;
            rd_dat = hi ? cnt_val[63:32] : cnt_val[31:0];
        end else if (csr.csr_addr == CSR_MCOUNTINHIBIT) begin
            hit    = 1'b1;
            rd_dat = inh_q;
        end
`ifdef CSR_OVF_IRQ_EN
        else if (csr.csr_addr == CSR_MCOUNTOVF) begin
            hit    = 1'b1;
            rd_dat = ovf_q;
        end
`endif
    end

    assign illegal = csr.csr_we && (csr.csr_op != CSR_OP_RD) &&
                     (csr.csr_addr[11:10] == 2'b11) && hit;
    assign wr_ok   = csr.csr_we && (csr.csr_op != CSR_OP_RD) && hit && !illegal;
    assign wr_dat  = csr_apply(csr.csr_op, rd_dat, csr.csr_wdata);

    assign csr.csr_rdata   = rd_dat;
    assign csr.csr_hit     = hit;
    assign csr.csr_illegal = illegal;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int BIT = (c == 0) ? INH_CY : (c == 1) ? INH_IR : INH_HPM0 + c - 2;
        logic evt;
        if (c == 0) begin : g_cy
            assign evt = 1'b1;
        end else if (c == 1) begin : g_ir
            assign evt = retire;
        end else begin : g_hpm
            assign evt = hpm_evt[c-2];
        end
        // Only the machine alias can reach here: user-alias writes are flagged illegal.
        assign ch_inc[c]   = evt && !inh_q[BIT];
        assign ch_we_lo[c] = wr_ok && ctr_sel && (sel_ch == c) && !hi;
        assign ch_we_hi[c] = wr_ok && ctr_sel && (sel_ch == c) && hi;

        csr_counter_cell #(.W(COUNTER_W)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .inc   (ch_inc[c]),
            .we_lo (ch_we_lo[c]),
            .we_hi (ch_we_hi[c]),
            .wdat  (wr_dat),
            .cnt   (cnt_q[c]),
            .wrap  (ch_wrap[c])
        );
    end

    always_comb begin
        wrap_bits = '0;
        for (int c = 0; c < NUM_CH; c++) wrap_bits[(c == 0) ? 0 : c + 1] = ch_wrap[c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            time_q <= '0;
            inh_q  <= '0;
        end else begin
            if (pre_q == PRE_LAST) begin
                pre_q  <= '0;
                time_q <= time_q + COUNTER_W'(1);
            end else begin
                pre_q  <= pre_q + PRE_W'(1);
            end
            if (wr_ok && csr.csr_addr == CSR_MCOUNTINHIBIT) inh_q <= wr_dat & CNT_MASK;
        end
    end

`ifdef CSR_OVF_IRQ_EN
    always_comb begin
        ovf_d = ovf_q;
        if (wr_ok && csr.csr_addr == CSR_MCOUNTOVF) ovf_d = wr_dat & CNT_MASK;
        ovf_d = ovf_d | wrap_bits;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q   <= '0;
            ovf_irq <= 1'b0;
        end else begin
            ovf_q   <= ovf_d;
            ovf_irq <= |ovf_d;
        end
    end
`else
    logic unused_wrap;
    assign unused_wrap = ^wrap_bits;
    assign ovf_irq     = 1'b0;
`endif

endmodule
